// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - single-outstanding CPU bus master with one-hot slave decode
// Optional feature macro: BUS_TIMEOUT_EN (abort BUSY after TIMEOUT_CYC cycles without ready).
`timescale 1ns/1ps

`ifndef BUS_DATA
`define BUS_DATA 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef DIS_EN
`define DIS_EN 5'b00000
`endif

module bus_master_if #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [`BUS_DATA-1:0] wr_data_i,
  output logic [31:0]          rd_data_o,
  output logic                 stall_o,
  output logic                 err_o,
  output logic [31:0]          bus_addr_o,
  output logic                 bus_we_o,
  output logic [`BUS_DATA-1:0] bus_wr_data_o,
  output logic                 c_en_s0_o,
  output logic                 c_en_s1_o,
  output logic                 c_en_s2_o,
  output logic                 c_en_s3_o,
  output logic                 c_en_s4_o,
  input  logic [31:0]          bus_rd_data_i,
  input  logic                 bus_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic [4:0] c_en;
  logic [4:0] dec_en;
  logic       mapped;

  // Region 5..7 shifts the single bit out of the 5-bit vector, but mapped masks it anyway.
  assign mapped = (addr_i[31:29] <= 3'd4);
  assign dec_en = mapped ? (5'd1 << addr_i[31:29]) : `DIS_EN;

  assign stall_o = (state == BUSY) || ((state == IDLE) && req_i);

  assign c_en_s0_o = c_en[0];
  assign c_en_s1_o = c_en[1];
  assign c_en_s2_o = c_en[2];
  assign c_en_s3_o = c_en[3];
  assign c_en_s4_o = c_en[4];

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      c_en          <= `DIS_EN;
      bus_addr_o    <= '0;
      bus_we_o      <= 1'b0;
      bus_wr_data_o <= '0;
      rd_data_o     <= `ZERO_WORD;
      err_o         <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            if (mapped) begin
              state         <= BUSY;
              c_en          <= dec_en;
              bus_addr_o    <= addr_i;
              bus_we_o      <= we_i;
              bus_wr_data_o <= wr_data_i;
`ifdef BUS_TIMEOUT_EN
              wait_cnt      <= '0;
`endif
            end else begin
              state     <= DONE;
              err_o     <= 1'b1;
              rd_data_o <= `ZERO_WORD;
            end
          end
        end
        BUSY: begin
          // Ready has priority over a timeout match in the same cycle.
          if (bus_ready_i) begin
            state     <= DONE;
            c_en      <= `DIS_EN;
            err_o     <= 1'b0;
            rd_data_o <= bus_we_o ? `ZERO_WORD : bus_rd_data_i;
          end
`ifdef BUS_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            state     <= DONE;
            c_en      <= `DIS_EN;
            err_o     <= 1'b1;
            rd_data_o <= `ZERO_WORD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - table-driven and random checks of bus_master_if against a transaction model
`timescale 1ns/1ps

module tb_bus_master_if;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] bus_rd = '0;
  logic        bus_ready = 1'b0;

  wire [31:0] rd_data;
  wire        stall;
  wire        err;
  wire [31:0] bus_addr;
  wire        bus_we;
  wire [31:0] bus_wr_data;
  wire        c0, c1, c2, c3, c4;

  int total = 0;
  int bad = 0;

  bus_master_if #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wr_data_i(wdata), .rd_data_o(rd_data), .stall_o(stall), .err_o(err),
    .bus_addr_o(bus_addr), .bus_we_o(bus_we), .bus_wr_data_o(bus_wr_data),
    .c_en_s0_o(c0), .c_en_s1_o(c1), .c_en_s2_o(c2), .c_en_s3_o(c3), .c_en_s4_o(c4),
    .bus_rd_data_i(bus_rd), .bus_ready_i(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives one access, plays the slave (ready after t_wait BUSY cycles) and checks the observed cycle counts.
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [31:0] t_rdata, input int t_wait, input int t_sel,
                         input logic [31:0] e_rd, input logic e_err, input int e_stalls,
                         input int e_en, input bit b2b, input bit noise_rand);
    int busy = 0;
    int stalls = 0;
    int en_cyc = 0;
    int cyc = 0;
    bit done = 0;
    logic [4:0] en;
    logic [4:0] exp_en;
    exp_en = (t_sel < 0) ? 5'd0 : 5'(1 << t_sel);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    while (!done && cyc < 400) begin
      en = {c4, c3, c2, c1, c0};
      if (en != 5'd0) begin
        busy++;
        bus_ready = (busy > t_wait);
        bus_rd = bus_ready ? t_rdata : $urandom;
      end else begin
        bus_ready = noise_rand ? 1'($urandom) : 1'b1;
        bus_rd = $urandom;
      end
      #4;
      en = {c4, c3, c2, c1, c0};
      if (en != 5'd0) begin
        en_cyc++;
        check("en_sel", {27'd0, en}, {27'd0, exp_en});
        check("bus_addr", bus_addr, t_addr);
        check("bus_we", {31'd0, bus_we}, {31'd0, t_we});
        check("bus_wr_data", bus_wr_data, t_wdata);
      end
      if (stall) stalls++;
      else begin
        done = 1;
        check("stall_cycles", stalls, e_stalls);
        check("en_cycles", en_cyc, e_en);
        check("rd_data", rd_data, e_rd);
        check("err", {31'd0, err}, {31'd0, e_err});
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_no_done: got no DONE within %0d cycles want DONE", cyc);
    end
    if (!b2b) begin
      req = 1'b0; bus_ready = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wt;
    int          sel;
    logic [31:0] rd;
    logic        err;
    int          stalls;
    int          en;
    bit          b2b;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 32'h4000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 1'b0, 2, 1, 1'b1};
    tbl[1] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1, 4, 32'hCAFE_F00D, 1'b0, 3, 2, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'hAAAA_5555, 3, 0, 32'h0000_0000, 1'b0, 5, 4, 1'b0};
    tbl[3] = '{1'b0, 32'hE000_0000, 32'h0000_0000, 32'h1111_1111, 0, -1, 32'h0000_0000, 1'b1, 1, 0, 1'b0};
    tbl[4] = '{1'b1, 32'h6000_0000, 32'h5A5A_5A5A, 32'h7777_7777, 0, 3, 32'h0000_0000, 1'b0, 2, 1, 1'b0};
    tbl[5] = '{1'b1, 32'hA000_0000, 32'h0F0F_0F0F, 32'h2222_2222, 0, -1, 32'h0000_0000, 1'b1, 1, 0, 1'b0};
    tbl[6] = '{1'b1, 32'hFFFF_FFFC, 32'h3333_3333, 32'h4444_4444, 0, -1, 32'h0000_0000, 1'b1, 1, 0, 1'b0};
    tbl[7] = '{1'b0, 32'h2000_0100, 32'h0000_0000, 32'h0BAD_C0DE, 2, 1, 32'h0BAD_C0DE, 1'b0, 4, 3, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_en", {27'd0, c4, c3, c2, c1, c0}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_wr_data", bus_wr_data, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_stall_req0", {31'd0, stall}, 32'd0);
    req = 1'b1; #1;
    check("rst_stall_req1", {31'd0, stall}, 32'd1);
    req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].wt, tbl[i].sel,
              tbl[i].rd, tbl[i].err, tbl[i].stalls, tbl[i].en, tbl[i].b2b, 1'b0);

    // Reset while an s3 read is waiting in BUSY.
    req = 1'b1; we = 1'b0; addr = 32'h6000_0020; wdata = 32'h9999_0000; bus_ready = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pre_en3", {31'd0, c3}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_en", {27'd0, c4, c3, c2, c1, c0}, 32'd0);
    check("mid_rst_bus_addr", bus_addr, 32'd0);
    check("mid_rst_bus_wr_data", bus_wr_data, 32'd0);
    check("mid_rst_rd_data", rd_data, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_stall_idle", {31'd0, stall}, 32'd1);
    req = 1'b0; #1;
    check("mid_rst_stall_req0", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef BUS_TIMEOUT_EN
    run_txn(1'b0, 32'h2000_0000, 32'h0, 32'h5555_AAAA, 1000, 1, 32'h0, 1'b1, TO + 1, TO, 1'b0, 1'b0);
    run_txn(1'b0, 32'h2000_0008, 32'h0, 32'h5555_AAAA, TO - 1, 1, 32'h5555_AAAA, 1'b0, TO + 1, TO, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      logic        r_we;
      logic [31:0] r_addr, r_wdata, r_rdata, e_rd;
      int          r_wait, busy_exp, sel;
      bit          mapped, timed_out;
      r_we = 1'($urandom);
      r_addr = {3'($urandom_range(0, 7)), 29'($urandom)};
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_wait = $urandom_range(0, 6);
      mapped = (r_addr[31:29] < 3'd5);
      sel = mapped ? int'(r_addr[31:29]) : -1;
      busy_exp = r_wait + 1;
      timed_out = 0;
`ifdef BUS_TIMEOUT_EN
      if (busy_exp > TO) begin busy_exp = TO; timed_out = 1; end
`endif
      if (!mapped)
        run_txn(r_we, r_addr, r_wdata, r_rdata, r_wait, sel, 32'h0, 1'b1, 1, 0, 1'(n % 3 == 0), 1'b1);
      else begin
        e_rd = (timed_out || r_we) ? 32'h0 : r_rdata;
        run_txn(r_we, r_addr, r_wdata, r_rdata, r_wait, sel, e_rd, timed_out,
                busy_exp + 1, busy_exp, 1'(n % 3 == 0), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
